// File: rtl/flag_branch_unit.sv
// Condition-flag register and branch resolver for a 64-bit ARM-style datapath.
// Holds {N,Z,C,V}, forwards same-cycle flag updates and registers the branch decision.
module flag_branch_unit #(
  parameter real delay = 0.05
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       zero,
  input  logic       negative,
  input  logic       carry_out,
  input  logic       overflow,
  input  logic       set_flags,
  input  logic       is_bcond,
  input  logic       is_cbz,
  input  logic [3:0] cond,
  output logic [3:0] flags,
  output logic       flags_valid,
  output logic       branch_taken
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Every output is registered, so delay only annotates timing models; reject nonsense values.
  if (delay < 0.0) begin : g_bad_delay
    $error("flag_branch_unit: delay must be non-negative");
  end

  logic [3:0] eff_flags;
  logic       eff_n;
  logic       eff_z;
  logic       eff_c;
  logic       eff_v;
  logic       cond_true;
  logic       decision;

  // Same-cycle forwarding lets a flag-setting op feed the B.cond it is fused with.
  always_comb begin
    eff_flags = set_flags ? {negative, zero, carry_out, overflow} : flags;
    eff_n     = eff_flags[3];
    eff_z     = eff_flags[2];
    eff_c     = eff_flags[1];
    eff_v     = eff_flags[0];
  end

  always_comb begin
    cond_true = 1'b1;
    unique case (cond_e'(cond))
      COND_EQ: cond_true = eff_z;
      COND_NE: cond_true = !eff_z;
      COND_CS: cond_true = eff_c;
      COND_CC: cond_true = !eff_c;
      COND_MI: cond_true = eff_n;
      COND_PL: cond_true = !eff_n;
      COND_VS: cond_true = eff_v;
      COND_VC: cond_true = !eff_v;
      COND_HI: cond_true = eff_c && !eff_z;
      COND_LS: cond_true = !eff_c || eff_z;
      COND_GE: cond_true = (eff_n == eff_v);
      COND_LT: cond_true = (eff_n != eff_v);
      COND_GT: cond_true = !eff_z && (eff_n == eff_v);
      COND_LE: cond_true = eff_z || (eff_n != eff_v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b1;
      default: cond_true = 1'b1;
    endcase
  end

  // CBZ tests the raw zero input and outranks B.cond.
  always_comb begin
    decision = 1'b0;
    if (is_cbz)
      decision = zero;
    else if (is_bcond)
      decision = cond_true;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags        <= '0;
      flags_valid  <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      if (set_flags) begin
        flags       <= {negative, zero, carry_out, overflow};
        flags_valid <= 1'b1;
      end
      branch_taken <= decision;
    end
  end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The module SHALL have parameter delay, default 0.05, giving the propagation delay in ns applied to every combinational output path.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset that clears all state immediately, independent of clk.
REQ-004 The module SHALL have port zero, input, 1 bit: the all-zero indication of the current 64-bit ALU result.
REQ-005 The module SHALL have port negative, input, 1 bit: bit 63 of the current ALU result.
REQ-006 The module SHALL have port carry_out, input, 1 bit: the ALU carry out of bit 63.
REQ-007 The module SHALL have port overflow, input, 1 bit: the ALU signed overflow.
REQ-008 The module SHALL have port set_flags, input, 1 bit: the current instruction is flag-setting (ADDS, SUBS, etc.).
REQ-009 The module SHALL have port is_bcond, input, 1 bit: the current instruction is B.cond.
REQ-010 The module SHALL have port is_cbz, input, 1 bit: the current instruction is CBZ, testing the ALU pass-through of Rt.
REQ-011 The module SHALL have port cond, input, 4 bits: the ARM condition field of B.cond.
REQ-012 The module SHALL have port flags, output, 4 bits: the stored flags {N,Z,C,V}, registered.
REQ-013 The module SHALL have port flags_valid, output, 1 bit: asserted once any flag-setting instruction has committed since reset, registered.
REQ-014 The module SHALL have port branch_taken, output, 1 bit: the registered branch decision for the instruction presented in the previous cycle.

Function
REQ-015 On a rising edge with set_flags=1, the module SHALL load flags with {negative, zero, carry_out, overflow}; with set_flags=0, flags SHALL hold.
REQ-016 On the first rising edge with set_flags=1 after reset, the module SHALL set flags_valid to 1; flags_valid SHALL then stay 1 until reset.
REQ-017 The module SHALL form the effective flags for evaluation as the incoming {negative, zero, carry_out, overflow} when set_flags=1 in the same cycle, and as the stored flags otherwise (same-cycle forwarding).
REQ-018 The module SHALL decode cond on the effective flags as follows:
- 0000 EQ: Z
- 0001 NE: !Z
- 0010 CS: C
- 0011 CC: !C
- 0100 MI: N
- 0101 PL: !N
- 0110 VS: V
- 0111 VC: !V
- 1000 HI: C & !Z
- 1001 LS: !C | Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: !Z & N==V
- 1101 LE: Z | N!=V
- 1110 and 1111: always true.
REQ-019 For CBZ, the module SHALL make the decision equal to the zero input of the same cycle, ignoring both stored flags and cond.
REQ-020 When is_cbz and is_bcond are both 1, is_cbz SHALL take priority.
REQ-021 When neither is_cbz nor is_bcond is 1, the decision SHALL be 0.
REQ-022 The module SHALL register the decision into branch_taken on the rising edge, giving exactly 1-cycle latency.
REQ-023 branch_taken SHALL be high for one cycle per taken branch and SHALL not be sticky.
REQ-024 While flags_valid=0, B.cond SHALL evaluate against the stored flags 0000 (e.g. EQ not taken, NE taken, GE taken); this is not an error condition.
REQ-025 For a CBZ with set_flags=1 in the same cycle, the flags update and the CBZ decision SHALL both occur independently.

Reset
REQ-026 While reset=1, flags SHALL be 4'b0000, flags_valid SHALL be 0, and branch_taken SHALL be 0, asynchronously and regardless of clk.
REQ-027 If reset asserts mid-operation, any pending decision SHALL be discarded, and no branch_taken pulse SHALL appear on the first edge after reset deasserts.
REQ-028 The first evaluation after reset deassertion SHALL use flags 0000 unless set_flags=1 in that cycle.

Verification
REQ-029 Bench scenario, flag load: after reset, apply set_flags=1 with N=1, Z=0, C=0, V=0, then one edge -> flags=4'b1000 and flags_valid=1; one further edge with set_flags=0 -> flags remain 4'b1000.
REQ-030 Bench scenario, forwarding: stored flags 0000; in one cycle apply set_flags=1, zero=1, is_bcond=1, cond=0000 -> branch_taken=1 after the edge; the same stimulus with set_flags=0 -> branch_taken=0.
REQ-031 Bench scenario, signed compares: with stored flags N=1, V=0 -> LT taken, GE not taken, GT not taken, LE taken; with N=1, V=1, Z=0 -> GT taken.
REQ-032 Bench scenario, CBZ priority: is_cbz=1, is_bcond=1, cond=1110, zero=0 -> branch_taken=0; then zero=1 -> branch_taken=1 for exactly one cycle.
REQ-033 Bench scenario, asynchronous reset: with flags=4'b1111 and branch_taken=1, assert reset between clock edges -> all outputs 0 before the next edge; deassert reset and apply is_bcond=1, cond=0000 -> branch_taken=0.
REQ-034 Bench scenario, conditions 1110/1111 and idle: cond=1110 and cond=1111 -> branch_taken=1 for any flags; is_bcond=0 and is_cbz=0 -> branch_taken=0 for any cond and zero.
